// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step is done per cycle; stall_req holds the pipeline meanwhile.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic [CNTW-1:0]    cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;
  logic               sgn_op_s;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Single iteration step and final sign correction.
  always_comb begin
    sgn_op_s    = ~op[0];
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
    acc_d       = acc_q;
    if (is_div_q) begin
      // Bit WIDTH of the difference is the borrow: set means the divisor did not fit.
      if (!div_diff_s[WIDTH]) begin
        acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
    prod_s   = (neg_a_q ^ neg_b_q) ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (is_div_q) begin
      fix_lo_s = abs_val(acc_q[WIDTH-1:0], neg_a_q ^ neg_b_q);
      fix_hi_s = abs_val(acc_q[2*WIDTH-1:WIDTH], neg_a_q);
    end else begin
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with HI/LO and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      cnt_q    <= {CNTW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                is_div_q <= op[1];
                neg_a_q  <= sgn_op_s & opA[WIDTH-1];
                neg_b_q  <= sgn_op_s & opB[WIDTH-1];
                // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                if (op[1]) begin
                  acc_q  <= {{WIDTH{1'b0}}, abs_val(opA, sgn_op_s & opA[WIDTH-1])};
                  opnd_q <= abs_val(opB, sgn_op_s & opB[WIDTH-1]);
                end else begin
                  acc_q  <= {{WIDTH{1'b0}}, abs_val(opB, sgn_op_s & opB[WIDTH-1])};
                  opnd_q <= abs_val(opA, sgn_op_s & opA[WIDTH-1]);
                end
                cnt_q   <= CNTW'(WIDTH);
                busy_q  <= 1'b1;
                state_q <= CALC;
              end
              3'd4:    hi_q <= opA;
              3'd5:    lo_q <= opA;
              default: ;
            endcase
          end else begin
            busy_q <= 1'b0;
          end
        end
        CALC: begin
          if (flush) begin
            cnt_q   <= {CNTW{1'b0}};
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
              state_q <= FIX;
            end else begin
              state_q <= CALC;
            end
          end
        end
        FIX: begin
          if (!flush) begin
            hi_q   <= fix_hi_s;
            lo_q   <= fix_lo_s;
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign stall_req = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32) using immediate assertions.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_err;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, ride out the busy window (optionally poking a stray start), then check results.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int poke_at);
    int cyc;
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, "_busy_on"}, {63'd0, stall_req}, 64'd1);
    cyc = 0;
    while (busy && cyc < 60) begin
      if (poke_at != 0 && cyc == poke_at) begin
        start = 1'b1; op = 3'd4; opA = 32'hDEADBEEF;
      end
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    @(posedge clock); #1;
    chk({tag, "_done_off"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; op = 3'd0; opA = 32'd0; opB = 32'd0; flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    run_op("mult_m3x5", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("mult_m1m1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0);
    run_op("multu_sh", 3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 0);
    run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div_minm1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op("divu_by0", 3'd3, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 0);
    run_op("div_negby0", 3'd2, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'h00000001, 0);
    run_op("div_posby0", 3'd2, 32'h00000055, 32'd0, 32'h00000055, 32'hFFFFFFFF, 0);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("start_busy", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    start = 1'b1; op = 3'd4; opA = 32'hA5A5A5A5;
    @(posedge clock); #1;
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
    chk("mthi_busy", {62'd0, busy, done}, 64'd0);
    op = 3'd5; opA = 32'h5A5A5A5A;
    @(posedge clock); #1;
    start = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'h5A5A5A5A});
    chk("mtlo_hi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
    chk("mtlo_busy", {62'd0, busy, done}, 64'd0);
    @(posedge clock); #1;
    chk("mtx_after", {62'd0, busy, done}, 64'd0);

    start = 1'b1; op = 3'd4; opA = 32'h11111111; flush = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start", {hi, 31'd0, busy}, {32'hA5A5A5A5, 32'd0});

    start = 1'b1; op = 3'd0; opA = 32'd3; opB = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_busy", {62'd0, busy, stall_req}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    chk("flush_hilo", {hi, lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    repeat (30) @(posedge clock);
    #1;
    chk("flush_quiet", {hi, lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});

    start = 1'b1; op = 3'd0; opA = 32'd3; opB = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_hilo", {hi, lo}, 64'd0);
    chk("rstmid_busy", {62'd0, busy, done}, 64'd0);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rstmid_idle", {62'd0, busy, done}, 64'd0);
    run_op("post_rst", 3'd1, 32'd7, 32'd6, 32'd0, 32'd42, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS 5-stage pipeline. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO from the EX stage. While a multi-cycle operation is in flight it raises a stall request to the hazard logic. WIDTH is parametrised so the same block serves the 32-bit core and narrower test configurations.

Parameters:
WIDTH, 32, operand and HI/LO width; legal values are even and >= 4.
CNTW, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  issue strobe from the EX stage; valid for one cycle.
op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
opA  input  WIDTH  rs operand; dividend or multiplicand; MTHI/MTLO source.
opB  input  WIDTH  rt operand; divisor or multiplier.
flush  input  1  aborts any in-flight operation.
busy  output  1  a multi-cycle operation is in flight.
stall_req  output  1  equals busy; hazard logic holds PC, IFID and IDEX while it is high.
done  output  1  one-cycle pulse after HI/LO are updated by MULT/DIV.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, reset==0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the operation with no HI/LO update.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1, flush=0:
  - op 0-3: latch absolute values of the operands (signed ops) or raw values (unsigned ops), latch sign flags, go to CALC, set counter=WIDTH, busy=1 on the next cycle.
  - op 4 (MTHI): hi<=opA on the same edge; state stays IDLE; busy and done stay 0.
  - op 5 (MTLO): lo<=opA on the same edge; state stays IDLE; busy and done stay 0.
  - op 6-7: ignored.
- CALC: one iteration per cycle; counter decrements; leave for FIX when counter reaches 1.
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle, WIDTH-bit remainder plus a carry bit.
- FIX: apply sign correction. Then hi<=upper product or remainder, lo<=lower product or quotient, done=1 for the following cycle, state=IDLE.
- Latency: start accepted at edge E; HI/LO updated at edge E+WIDTH+1; busy high from E through E+WIDTH+1; done high for the cycle after E+WIDTH+1.
- Signed rules:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - MIN/-1 gives lo=MIN, hi=0 with no trap.
- Divide by zero completes with normal latency and no trap:
  - DIVU: lo=all ones, hi=opA.
  - DIV: hi=opA; lo=all ones if opA>=0, else lo=1.
- start while busy: ignored. The pipeline is stalled, so this only happens on protocol error; it has no effect.
- flush: in CALC or FIX, return to IDLE on the next edge with hi/lo unchanged, done=0, busy=0. flush and start together in IDLE: flush wins and start is ignored.
- hi/lo are readable every cycle; MFHI/MFLO correctness relies on the stall while busy.

Test Plan:
- Reset released, then MULT opA=0xFFFFFFFD (-3), opB=5 -> busy for 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU opA=opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then MULT with the same operands -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0xFFFFFFF0/0 -> lo=1, hi=0xFFFFFFF0.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A in consecutive cycles -> hi/lo update on the issuing edges; busy and done never assert. A second start during busy has no effect.
- Abort cases:
  - MULT started, flush asserted 10 cycles later -> busy drops next edge, no done, hi/lo keep their previous values.
  - Repeat the MULT with reset pulsed low mid-operation -> hi=lo=0 immediately.
